// File: rtl/pace_pingpong_inp_pkg.sv
// Shared PACE typedefs: ping-pong input splitter state and byte-strobe granularity.
package pace_pingpong_inp_pkg;

    localparam int unsigned PaceBitsPerStrb = 8;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        LO    = 2'd1,
        HI    = 2'd2
    } pace_pp_state_e;

    function automatic logic pace_pp_is_hi(input pace_pp_state_e s);
        return s == HI;
    endfunction

endpackage

// File: rtl/pace_pingpong_inp_if.sv
// Valid/ready stream carrying a data word plus byte strobes.
interface hwpe_stream_intf_stream #(
    parameter int unsigned DATA_WIDTH = 32
);
    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

    logic                  valid;
    logic                  ready;
    logic [DATA_WIDTH-1:0] data;
    logic [STRB_WIDTH-1:0] strb;

    modport source (output valid, data, strb, input ready);
    modport sink   (input valid, data, strb, output ready);
    modport master (output valid, data, strb, input ready);
    modport slave  (input valid, data, strb, output ready);
endinterface

// File: rtl/pace_pingpong_inp.sv
// Splits each wide memory beat into two engine half-beats (low then high),
// skipping the high half when its strobes are all clear.
module pace_pingpong_inp
    import pace_pingpong_inp_pkg::*;
#(
    parameter int unsigned NumRows   = 8,
    parameter int unsigned DataWidth = 16
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic                                clear_i,
    input  logic                                enable_i,
    hwpe_stream_intf_stream.sink                input_i,
    output logic [NumRows-1:0][DataWidth-1:0]   data_o,
    output logic                                valid_o,
    input  logic                                ready_i,
    output logic                                half_o
);

    localparam int unsigned HalfW     = NumRows * DataWidth;
    localparam int unsigned BeatW     = 2 * HalfW;
    localparam int unsigned StrbW     = BeatW / PaceBitsPerStrb;
    localparam int unsigned HalfStrbW = StrbW / 2;

    pace_pp_state_e   state_q, state_d;
    logic [BeatW-1:0] beat_q;
    logic [StrbW-1:0] strb_q;

    logic in_ready, in_hs, out_hs, hi_live;

    assign valid_o  = enable_i & (state_q != EMPTY);
    assign out_hs   = valid_o & ready_i;
    // New beat only lands while the buffer is free or its last half is leaving now.
    assign in_ready = enable_i & ~clear_i &
                      ((state_q == EMPTY) | ((state_q == HI) & out_hs));
    assign in_hs    = input_i.valid & in_ready;
    assign input_i.ready = in_ready;

    // Low-half strobes never suppress output; only the high half is qualified.
    assign hi_live = |strb_q[StrbW-1:HalfStrbW];

    logic unused_lo_strb;
    assign unused_lo_strb = ^strb_q[HalfStrbW-1:0];

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            EMPTY:   if (in_hs)  state_d = LO;
            LO:      if (out_hs) state_d = hi_live ? HI : EMPTY;
            HI:      if (out_hs) state_d = in_hs ? LO : EMPTY;
            default: state_d = EMPTY;
        endcase
        if (clear_i) state_d = EMPTY;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            beat_q <= '0;
            strb_q <= '0;
        end else if (clear_i) begin
            beat_q <= '0;
            strb_q <= '0;
        end else if (in_hs) begin
            beat_q <= input_i.data;
            strb_q <= input_i.strb;
        end
    end

    // Output is a pure mux of registers, so no input-to-output data path exists.
    assign half_o = pace_pp_is_hi(state_q);
    assign data_o = half_o ? beat_q[BeatW-1:HalfW] : beat_q[HalfW-1:0];

endmodule

// File: tb/tb_pace_pingpong_inp.sv
// Scoreboard bench for pace_pingpong_inp: halves queued on input handshakes, popped on output handshakes.
module tb_pace_pingpong_inp;

    localparam int unsigned NR = 8;
    localparam int unsigned DW = 16;
    localparam int unsigned HW = NR * DW;
    localparam int unsigned BW = 2 * HW;
    localparam int unsigned SW = BW / 8;

    typedef struct {
        logic          half;
        logic [HW-1:0] data;
    } exp_t;

    logic clk, rst_n, clear, enable, ready_i, valid_o, half_o;
    logic [NR-1:0][DW-1:0] data_o;
    logic [HW-1:0] data_flat;
    assign data_flat = data_o;

    int checks = 0;
    int errors = 0;
    exp_t sb[$];
    exp_t e;

    hwpe_stream_intf_stream #(.DATA_WIDTH(BW)) inp ();

    pace_pingpong_inp #(.NumRows(NR), .DataWidth(DW)) dut (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .enable_i(enable),
        .input_i(inp), .data_o(data_o), .valid_o(valid_o),
        .ready_i(ready_i), .half_o(half_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [BW-1:0] mk(input logic [7:0] lo, input logic [7:0] hi);
        return {{16{hi}}, {16{lo}}};
    endfunction

    // Scoreboard: expected halves come from observed input handshakes.
    always @(negedge clk) begin
        if (rst_n && !clear) begin
            if (valid_o && ready_i) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected half=%0b data=%h", half_o, data_flat);
                end else begin
                    e = sb.pop_front();
                    if (half_o !== e.half || data_flat !== e.data) begin
                        errors++;
                        $display("FAIL sb_half got half=%0b data=%h exp half=%0b data=%h",
                                 half_o, data_flat, e.half, e.data);
                    end
                end
            end
            if (inp.valid && inp.ready) begin
                sb.push_back('{half: 1'b0, data: inp.data[HW-1:0]});
                if (|inp.strb[SW-1:SW/2]) sb.push_back('{half: 1'b1, data: inp.data[BW-1:HW]});
            end
        end
    end

    task automatic send_beat(input logic [BW-1:0] d, input logic [SW-1:0] s);
        int n = 0;
        inp.valid = 1'b1; inp.data = d; inp.strb = s;
        @(negedge clk);
        while (!inp.ready) begin
            n++;
            if (n > 200) begin
                checks++; errors++;
                $display("FAIL send_timeout ready=%0b exp 1", inp.ready);
                break;
            end
            @(negedge clk);
        end
        @(posedge clk); #1;
        inp.valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin @(negedge clk); n++; end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain left=%0d exp 0", sb.size());
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; enable = 1'b0; clear = 1'b0; ready_i = 1'b1;
        inp.valid = 1'b0; inp.data = '0; inp.strb = '0;
        repeat (2) @(negedge clk);
        checks++;
        if (valid_o !== 1'b0 || half_o !== 1'b0 || data_flat !== '0 || inp.ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_outs valid=%0b half=%0b data=%h rdy=%0b exp 0 0 0 0",
                     valid_o, half_o, data_flat, inp.ready);
        end
        enable = 1'b1;
        @(negedge clk);
        checks++;
        if (inp.ready !== 1'b1 || valid_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_enabled rdy=%0b valid=%0b exp 1 0", inp.ready, valid_o);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        logic [BW-1:0] b;
        b = {{16{8'hBB}}, {16{8'hAA}}};
        send_beat(b, '1);
        @(negedge clk);
        checks++;
        if (valid_o !== 1'b1 || half_o !== 1'b0 || data_flat !== b[HW-1:0]) begin
            errors++;
            $display("FAIL single_lo valid=%0b half=%0b data=%h exp 1 0 %h", valid_o, half_o, data_flat, b[HW-1:0]);
        end
        @(negedge clk);
        checks++;
        if (valid_o !== 1'b1 || half_o !== 1'b1 || data_flat !== b[BW-1:HW]) begin
            errors++;
            $display("FAIL single_hi valid=%0b half=%0b data=%h exp 1 1 %h", valid_o, half_o, data_flat, b[BW-1:HW]);
        end
        @(negedge clk);
        checks++;
        if (valid_o !== 1'b0) begin
            errors++;
            $display("FAIL single_end valid=%0b exp 0", valid_o);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        fork
            begin
                for (int i = 0; i < 4; i++)
                    send_beat(mk(8'(8'h10 + 2 * i), 8'(8'h11 + 2 * i)), '1);
            end
            begin
                int n = 0;
                @(negedge clk);
                while (!valid_o && n < 20) begin n++; @(negedge clk); end
                for (int k = 0; k < 8; k++) begin
                    checks++;
                    if (valid_o !== 1'b1 || half_o !== k[0] || inp.ready !== k[0]) begin
                        errors++;
                        $display("FAIL stream_%0d valid=%0b half=%0b rdy=%0b exp 1 %0b %0b",
                                 k, valid_o, half_o, inp.ready, k[0], k[0]);
                    end
                    @(negedge clk);
                end
            end
        join
        drain();
    endtask

    task automatic test_tail();
        send_beat(mk(8'hC1, 8'hC2), {{(SW/2){1'b0}}, {(SW/2){1'b1}}});
        @(negedge clk);
        checks++;
        if (valid_o !== 1'b1 || half_o !== 1'b0 || inp.ready !== 1'b0) begin
            errors++;
            $display("FAIL tail_lo valid=%0b half=%0b rdy=%0b exp 1 0 0", valid_o, half_o, inp.ready);
        end
        @(posedge clk); #1;
        inp.valid = 1'b1; inp.data = mk(8'hD1, 8'hD2); inp.strb = {{(SW/2){1'b1}}, {(SW/2){1'b0}}};
        @(negedge clk);
        checks++;
        if (valid_o !== 1'b0 || inp.ready !== 1'b1) begin
            errors++;
            $display("FAIL tail_empty valid=%0b rdy=%0b exp 0 1", valid_o, inp.ready);
        end
        @(posedge clk); #1;
        inp.valid = 1'b0;
        @(negedge clk);
        checks++;
        if (valid_o !== 1'b1 || half_o !== 1'b0 || data_flat !== {16{8'hD1}}) begin
            errors++;
            $display("FAIL tail_next valid=%0b half=%0b data=%h exp 1 0 d1..", valid_o, half_o, data_flat);
        end
        drain();
    endtask

    task automatic test_backpressure();
        ready_i = 1'b0;
        send_beat(mk(8'h31, 8'h32), '1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if (valid_o !== 1'b1 || half_o !== 1'b0 || data_flat !== {16{8'h31}} || inp.ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold_%0d valid=%0b half=%0b data=%h rdy=%0b exp 1 0 31.. 0",
                         k, valid_o, half_o, data_flat, inp.ready);
            end
        end
        @(posedge clk); #1;
        ready_i = 1'b1;
        drain();
    endtask

    task automatic test_clear_enable();
        send_beat(mk(8'h41, 8'h42), '1);
        @(posedge clk); #1;
        inp.valid = 1'b1; inp.data = mk(8'h51, 8'h52); inp.strb = '1;
        clear = 1'b1;
        @(negedge clk);
        checks++;
        if (inp.ready !== 1'b0) begin
            errors++;
            $display("FAIL clear_ready rdy=%0b exp 0", inp.ready);
        end
        @(posedge clk); #1;
        clear = 1'b0; inp.valid = 1'b0;
        sb.delete();
        @(negedge clk);
        checks++;
        if (valid_o !== 1'b0 || half_o !== 1'b0 || data_flat !== '0) begin
            errors++;
            $display("FAIL clear_outs valid=%0b half=%0b data=%h exp 0 0 0", valid_o, half_o, data_flat);
        end
        @(posedge clk); #1;
        send_beat(mk(8'h61, 8'h62), '1);
        enable = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (valid_o !== 1'b0 || inp.ready !== 1'b0) begin
                errors++;
                $display("FAIL enable_low_%0d valid=%0b rdy=%0b exp 0 0", k, valid_o, inp.ready);
            end
        end
        @(posedge clk); #1;
        enable = 1'b1;
        @(negedge clk);
        checks++;
        if (valid_o !== 1'b1 || half_o !== 1'b0 || data_flat !== {16{8'h61}}) begin
            errors++;
            $display("FAIL enable_resume valid=%0b half=%0b data=%h exp 1 0 61..", valid_o, half_o, data_flat);
        end
        drain();
    endtask

    task automatic test_reset_mid();
        send_beat(mk(8'h71, 8'h72), '1);
        rst_n = 1'b0;
        sb.delete();
        @(negedge clk);
        checks++;
        if (valid_o !== 1'b0 || half_o !== 1'b0 || data_flat !== '0 || inp.ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid valid=%0b half=%0b data=%h rdy=%0b exp 0 0 0 1",
                     valid_o, half_o, data_flat, inp.ready);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        send_beat(mk(8'h81, 8'h82), '1);
        @(negedge clk);
        checks++;
        if (valid_o !== 1'b1 || half_o !== 1'b0 || data_flat !== {16{8'h81}}) begin
            errors++;
            $display("FAIL rst_after valid=%0b half=%0b data=%h exp 1 0 81..", valid_o, half_o, data_flat);
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_tail();
        test_backpressure();
        test_clear_enable();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time=%0t exp finish earlier", $time);
        $fatal(1);
    end

endmodule
